// File: rtl/memory_pkg.sv
// Shared types and constants for the memory arbiter and its bank.
// State encoding, requester ids and default line geometry.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 256;
    localparam int DEFAULT_ADDR_WIDTH = 2;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin select between the fetch and data requesters.
// A lone requester wins; a tie goes to the port not granted last.
module mem_rr_pick
    import memory_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Sole requester wins, a tie alternates away from the last winner
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = PORT_IFETCH;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = PORT_DATA;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter and latency sequencer in front of memory_bank.
// One access in flight; a one-cycle ack closes each access.
module memory_arbiter
    import memory_pkg::*;
#(
    parameter int MEMORY_DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int MEMORY_ADDRESS_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LATENCY              = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req0,
    input  logic                            req1,
    input  logic                            we0,
    input  logic                            we1,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] addr0,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] addr1,
    input  logic [MEMORY_DATA_WIDTH-1:0]    wdata0,
    input  logic [MEMORY_DATA_WIDTH-1:0]    wdata1,
    output logic                            ack0,
    output logic                            ack1,
    output logic [MEMORY_DATA_WIDTH-1:0]    rdata,
    output logic                            busy,
    output logic                            mem_write,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_in,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_out,
    output logic [MEMORY_DATA_WIDTH-1:0]    mem_data_in,
    input  logic [MEMORY_DATA_WIDTH-1:0]    mem_data_out
);

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t                          state;
    state_t                          next_state;
    logic [7:0]                      cnt;
    logic                            last_grant;
    logic                            lat_id;
    logic                            lat_we;
    logic [MEMORY_ADDRESS_WIDTH-1:0] lat_addr;
    logic [MEMORY_DATA_WIDTH-1:0]    lat_wdata;
    logic                            grant_valid;
    logic                            grant_id;
    logic                            start;
    logic                            finish;

    mem_rr_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign start  = (state == IDLE) && grant_valid;
    assign finish = (state == BUSY) && (cnt == 8'd0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and bank/requester outputs
    always_comb begin
        next_state   = state;
        busy         = (state != IDLE);
        ack0         = 1'b0;
        ack1         = 1'b0;
        mem_write    = 1'b0;
        mem_addr_in  = lat_addr;
        mem_addr_out = lat_addr;
        mem_data_in  = lat_wdata;
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                mem_write = lat_we && (cnt == 8'd0);
                if (cnt == 8'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                ack0       = (lat_id == PORT_IFETCH);
                ack1       = (lat_id == PORT_DATA);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Grant latch, latency countdown and read capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 8'd0;
            last_grant <= PORT_DATA;
            lat_id     <= PORT_IFETCH;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata      <= '0;
        end else begin
            if (start) begin
                cnt        <= CNT_INIT;
                last_grant <= grant_id;
                lat_id     <= grant_id;
                lat_we     <= grant_id ? we1 : we0;
                lat_addr   <= grant_id ? addr1 : addr0;
                lat_wdata  <= grant_id ? wdata1 : wdata0;
            end else if (state == BUSY && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (finish && !lat_we) begin
                rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and access sequencer placed in front of `memory_bank`. Shares the single bank between the instruction-fetch requester (port 0) and the data-access requester (port 1) using round-robin priority. Models main-memory latency with a programmable cycle count. Drives the bank's write/read address, data and write-enable, and returns line data with a one-cycle acknowledge. Does not instantiate `memory_bank`; the parent connects the `mem_*` ports to it.

## Interface

- `MEMORY_DATA_WIDTH`, 256, line width in bits, equal to the bank's.
- `MEMORY_ADDRESS_WIDTH`, 2, line address width, equal to the bank's.
- `LATENCY`, 5, cycles from grant to result; legal range 1..255.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request, held high until the matching ack.
- `we0`, `we1`  in  1  1 = write line, 0 = read line; stable while req high.
- `addr0`, `addr1`  in  MEMORY_ADDRESS_WIDTH  line address; stable while req high.
- `wdata0`, `wdata1`  in  MEMORY_DATA_WIDTH  write line; stable while req high.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  MEMORY_DATA_WIDTH  read result, valid while either ack is high.
- `busy`  out  1  high in any state other than IDLE.
- `mem_write`  out  1  to bank `write`.
- `mem_addr_in`  out  MEMORY_ADDRESS_WIDTH  to bank `addr_in`.
- `mem_addr_out`  out  MEMORY_ADDRESS_WIDTH  to bank `addr_out`.
- `mem_data_in`  out  MEMORY_DATA_WIDTH  to bank `data_in`.
- `mem_data_out`  in  MEMORY_DATA_WIDTH  from bank `data_out`; combinational read of `mem_addr_out`.

## Operation

- FSM states are IDLE, BUSY and RESP.
- **IDLE.** On an edge with any req high:
  - Pick a port.
  - Latch its id, we, addr and wdata.
  - Load `cnt = LATENCY-1` and go to BUSY.
  - With no request, stay in IDLE.
- **Round-robin pick.** One requester wins outright. If both request, the winner is the port ≠ `last_grant`. `last_grant` is updated on every grant and resets to 1, so port 0 wins the first tie.
- **BUSY.**
  - `mem_addr_in` and `mem_addr_out` both carry the latched addr; `mem_data_in` carries the latched wdata.
  - While `cnt != 0`, each edge decrements `cnt`.
  - When `cnt == 0`, the next edge goes to RESP.
  - If the latched op is a write, `mem_write` is high only in the cycle where `cnt == 0`, so it commits on the edge into RESP.
  - If the latched op is a read, `rdata` loads `mem_data_out` on the edge into RESP.
- **RESP.**
  - The granted port's ack is high for exactly one cycle.
  - For a write, `rdata` holds its previous value.
  - The next edge goes to IDLE unconditionally. No request is sampled in RESP, which guarantees one idle bubble.
- **Requester rule.** Drop req (or present a new op) at the edge ending the ack cycle. A req still high in IDLE is treated as a new request.
- `mem_write` is never high outside BUSY with `cnt == 0`.
- Requests that arrive during BUSY/RESP wait; they are not lost.

## Timing

- **Latency.** Request sampled at edge k:
  - Ack is high in the cycle after edge k+LATENCY.
  - For a write, `mem_write` is high in the cycle after edge k+LATENCY-1.
- **Throughput.** Back-to-back accesses start at most every LATENCY+2 cycles.
- **`LATENCY = 1`.** BUSY lasts one cycle with `cnt == 0`.
- **Reset values.** State IDLE, `cnt` 0, `last_grant` 1, `ack0`/`ack1` 0, `busy` 0, `mem_write` 0, `rdata` 0, and all latched addr/data 0.
- **Reset mid-operation.** The access is aborted. A write not yet committed is never committed. No ack is issued.
- **Read-after-write.** Same address, write then read: the read returns the written data, because the write commits before the read is granted.

## Structure

- **Package `memory_pkg`.** Holds:
  - the state encoding (IDLE = 0, BUSY = 1, RESP = 2);
  - the port id constants (`PORT_IFETCH = 0`, `PORT_DATA = 1`);
  - the default width constants shared with `memory_bank`.
- **Sub-module `mem_rr_pick`.** Combinational 2-way round-robin select.
  - Inputs: `req0`, `req1`, `last_grant`.
  - Outputs: `grant_valid`, `grant_id`.
- Counter, latches and FSM stay in `memory_arbiter`.

## Test plan

All scenarios use LATENCY = 5.

1. **Single read.** Bank preloaded with line 2 = 0xAB…AB. Port 0 reads addr 2, sampled at edge 10 → `ack0` high in the cycle after edge 15, `rdata` = 0xAB…AB, `ack1` stays 0, `mem_write` never high.
2. **Write then read.** Port 1 writes 0x4 to addr 1, then reads addr 1 → `mem_write` pulses exactly one cycle before `ack1`; the read returns 0x4.
3. **Tie.** Both ports request from edge 10 → port 0 acks first (cycle after edge 15), port 1 next (granted at edge 17, ack after edge 22). The next tie goes to port 0 again.
4. **Saturation.** Both ports request continuously → grants strictly alternate, with starts spaced 7 cycles apart.
5. **Reset during write.** Reset asserted during BUSY with `cnt` = 2 on a write to addr 3 → outputs reach reset values immediately, no ack, and line 3 is unchanged.
6. **`LATENCY = 1`.** Read sampled at edge k → ack in the cycle after edge k+1.
